fifo_sync_8x32: RTL and testbench
=================================

// Module: fifo_sync_8x32
// PURPOSE
//  Single-clock synchronous FIFO: 8 entries x 32 bits, chip-select gated.
//  Buffers data words between a producer and a consumer in the same clock domain.
//  Provides registered read data and combinational empty/full status flags.
// PARAMETERS
//  DATA_W  32  width of data_in/data_out and of each storage word
//  DEPTH   8   number of storage entries (power of two)
//  ADDR_W  3   log2(DEPTH); read/write pointers are ADDR_W+1 bits (wrap bit)
// PORTS
//  clk       in   1       clock; all state changes on rising edge
//  rst       in   1       synchronous, active-low reset
//  cs        in   1       chip select; 0 = no read/write accepted
//  wr_en     in   1       write request, qualified by cs
//  rd_en     in   1       read request, qualified by cs
//  data_in   in   DATA_W  write data, sampled on write edge
//  data_out  out  DATA_W  registered read data
//  empty     out  1       1 when FIFO holds 0 words
//  full      out  1       1 when FIFO holds DEPTH words
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low.
//  - Reset (rst=0 at rising edge): wr_ptr=0, rd_ptr=0, data_out=0, so empty=1 and full=0.
//    Memory contents are not cleared. Reset overrides any concurrent request.
//  - Reset mid-operation discards all stored words; they are never read out.
//  - Write accept = cs & wr_en & ~full, using the flag value before the edge.
//    On accept: mem[wr_ptr[ADDR_W-1:0]] <= data_in; wr_ptr <= wr_ptr+1.
//  - Read accept = cs & rd_en & ~empty, using the flag value before the edge.
//    On accept: data_out <= mem[rd_ptr[ADDR_W-1:0]]; rd_ptr <= rd_ptr+1.
//    Latency: data is valid on data_out right after the accepting edge.
//  - data_out holds its last value whenever no read is accepted, including
//    rd_en held high while empty and cs=0.
//  - Write while full: ignored, with no pointer or memory change.
//    Read while empty: ignored, with no pointer or data_out change. No error flag.
//  - Simultaneous accepted read and write: both happen in the same edge and the
//    occupancy is unchanged.
//      - When empty: only the write is accepted. The new word is readable on a
//        later cycle, so data does not pass through in the same cycle.
//      - When full: only the read is accepted.
//  - Pointers wrap modulo 2*DEPTH, and addresses wrap modulo DEPTH.
//  - empty = (wr_ptr == rd_ptr).
//  - full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]).
//  - Flags are combinational from the pointer registers and update in the cycle
//    after the accepting edge.
//  - Order is strictly first-in first-out. Data width is unchanged and no
//    arithmetic is done on data.
// TESTING
//  1. rst=0 one cycle, then rst=1 -> empty=1, full=0, data_out=0.
//  2. Write 1, 10, 100 with rd_en=0. Then hold rd_en=1 for 3 cycles -> data_out
//     1, 10, 100 in order, then empty=1.
//  3. Keep rd_en=1. Alternate write/read of 2**i for i=0..6 -> each value (1..64)
//     appears on data_out one read after its write. A read while empty keeps the
//     prior data_out.
//  4. Write 8 words 0..7 -> full=1. A 9th write of 99 is ignored. Reading 8 words
//     gives 0..7, and 99 never appears.
//  5. Continuous wr/rd across more than 16 words to exercise pointer wrap ->
//     FIFO order is preserved, and full/empty are correct at each boundary.
//  6. cs=0 with wr_en=rd_en=1 -> no pointer, flag or data_out change. Reset while
//     holding 5 words -> empty=1 and data_out=0 on the next cycle.

Source files
------------

// File: rtl/fifo_sync_8x32.sv
// Single-clock FIFO with chip-select gating, registered read data and
// combinational empty/full flags derived from wrap-bit pointers.
module fifo_sync_8x32 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr, rd_ptr;
    logic              wr_acc, rd_acc;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wr_acc = cs & wr_en & ~full;
    assign rd_acc = cs & rd_en & ~empty;

    // Storage is never cleared; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && wr_acc)
            mem[wr_ptr[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                data_out <= mem[rd_ptr[ADDR_W-1:0]];
                rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_8x32.sv
// Scoreboard bench for fifo_sync_8x32: a queue model predicts data_out and flags.
module tb_fifo_sync_8x32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        empty, full;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_dout = '0;

    fifo_sync_8x32 dut (
        .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .data_in(data_in), .data_out(data_out), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model using pre-edge occupancy, then check.
    task automatic step(input logic c, input logic w, input logic r, input logic [31:0] d,
                        input string tag);
        bit wa, ra;
        cs = c; wr_en = w; rd_en = r; data_in = d;
        wa = c && w && (sb_q.size() < 8);
        ra = c && r && (sb_q.size() > 0);
        @(posedge clk); #1;
        if (ra) exp_dout = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        chk({tag, ".dout"},  data_out, exp_dout);
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, sb_q.size() == 0});
        chk({tag, ".full"},  {31'd0, full},  {31'd0, sb_q.size() == 8});
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0; cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 32'hDEAD;
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        exp_dout = '0;
        chk({tag, ".dout"},  data_out, 32'd0);
        chk({tag, ".empty"}, {31'd0, empty}, 32'd1);
        chk({tag, ".full"},  {31'd0, full},  32'd0);
    endtask

    initial begin
        #1;
        // 1: reset
        do_reset("rst");

        // 2: three writes, then three reads
        step(1, 1, 0, 32'd1,   "w1");
        step(1, 1, 0, 32'd10,  "w10");
        step(1, 1, 0, 32'd100, "w100");
        for (int i = 0; i < 3; i++) step(1, 0, 1, 32'd0, "rd3");
        chk("t2.empty", {31'd0, empty}, 32'd1);
        chk("t2.last", data_out, 32'd100);

        // 3: rd_en held high, alternate write/read of powers of two
        for (int i = 0; i <= 6; i++) begin
            step(1, 1, 1, 32'd1 << i, "alt.w");
            step(1, 0, 1, 32'd0, "alt.r");
            chk("alt.val", data_out, 32'd1 << i);
        end
        step(1, 0, 1, 32'd0, "alt.hold");
        chk("alt.keep", data_out, 32'd64);

        // 4: fill, overflow write ignored, drain
        for (int i = 0; i < 8; i++) step(1, 1, 0, 32'(i), "fill");
        chk("t4.full", {31'd0, full}, 32'd1);
        step(1, 1, 0, 32'd99, "ovf");
        step(1, 1, 1, 32'd99, "full.rw");
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 32'd0, "drain");
            chk("drain.not99", {31'd0, data_out == 32'd99}, 32'd0);
        end
        step(1, 0, 1, 32'd0, "udf");

        // 5: wrap the pointers with continuous traffic
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'd1000 + 32'(i), "pre");
        for (int i = 0; i < 24; i++) step(1, 1, 1, 32'd2000 + 32'(i), "wrap");
        for (int i = 0; i < 4; i++) step(1, 1, 0, 32'd3000 + 32'(i), "top");
        for (int i = 0; i < 40; i++)
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, "rnd");
        while (sb_q.size() > 0) step(1, 0, 1, 32'd0, "flush");

        // 6: chip select off freezes everything; reset drops stored words
        step(1, 1, 0, 32'd77, "cs.pre");
        step(0, 1, 1, 32'd55, "cs0");
        step(0, 1, 1, 32'd56, "cs0b");
        step(1, 0, 1, 32'd0, "cs.post");
        chk("cs.val", data_out, 32'd77);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 32'd500 + 32'(i), "pre.rst");
        do_reset("rst2");
        step(1, 0, 1, 32'd0, "post.rst");
        step(1, 1, 0, 32'd42, "new.w");
        step(1, 0, 1, 32'd0, "new.r");
        chk("new.val", data_out, 32'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
